// File: rtl/dmem_axi_slave.sv
// dmem_axi_slave: AXI-style data memory slave, independent read/write burst channels, programmable read latency.
// Define DMEM_ERR_RESP_EN to flag out-of-range beats with SLVERR instead of wrapping the word index.
module dmem_axi_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int MW = $clog2(DEPTH_WORDS);
  localparam logic [IW:0] ONE = 1;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  r_state_t r_state_q, r_state_d;
  logic [3:0] r_cnt_q, r_cnt_d;
  logic [IW:0] r_idx_q, r_idx_d, r_fetch;
  logic [7:0] r_left_q, r_left_d;
  logic r_load, r_oor;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0] rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  w_state_t w_state_q, w_state_d;
  logic [IW:0] w_idx_q, w_idx_d;
  logic [7:0] w_left_q, w_left_d;
  logic w_err_q, w_err_d, w_oor, w_en;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0] bresp_q, bresp_d;
  logic unused_ok;
  // Index carries one spare MSB so a burst running past the top of the address space still reads as out of range.
`ifdef DMEM_ERR_RESP_EN
  assign w_oor = |w_idx_q[IW:MW];
`else
  assign w_oor = 1'b0;
`endif
  assign unused_ok = ^{araddr[1:0], awaddr[1:0], r_fetch[IW:MW], w_idx_q[IW:MW]};
  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d = r_cnt_q;
    r_idx_d = r_idx_q;
    r_left_d = r_left_q;
    r_fetch = r_idx_q;
    r_load = 1'b0;
    case (r_state_q)
      R_IDLE: if (arvalid) begin
        r_idx_d = {1'b0, araddr[ADDR_WIDTH-1:2]};
        r_fetch = {1'b0, araddr[ADDR_WIDTH-1:2]};
        r_left_d = arlen;
        r_cnt_d = 4'(LATENCY - 1);
        r_load = (LATENCY == 0);
        r_state_d = (LATENCY == 0) ? R_DATA : R_WAIT;
      end
      R_WAIT: if (r_cnt_q == 4'd0) begin
        r_state_d = R_DATA;
        r_load = 1'b1;
      end else r_cnt_d = r_cnt_q - 4'd1;
      R_DATA: if (rready) begin
        if (r_left_q == 8'd0) r_state_d = R_IDLE;
        else begin
          r_idx_d = r_idx_q + ONE;
          r_fetch = r_idx_q + ONE;
          r_left_d = r_left_q - 8'd1;
          r_load = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
`ifdef DMEM_ERR_RESP_EN
    r_oor = |r_fetch[IW:MW];
`else
    r_oor = 1'b0;
`endif
    arready_d = r_state_d == R_IDLE;
    rvalid_d = r_state_d == R_DATA;
    rlast_d = rvalid_d && r_left_d == 8'd0;
    rdata_d = !rvalid_d ? '0 : r_load ? (r_oor ? '0 : mem[r_fetch[MW-1:0]]) : rdata_q;
    rresp_d = !rvalid_d ? 2'b00 : r_load ? {r_oor, 1'b0} : rresp_q;
  end
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d = w_idx_q;
    w_left_d = w_left_q;
    w_err_d = w_err_q;
    w_en = 1'b0;
    case (w_state_q)
      W_IDLE: if (awvalid) begin
        w_idx_d = {1'b0, awaddr[ADDR_WIDTH-1:2]};
        w_left_d = awlen;
        w_err_d = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid) begin
        w_en = !w_oor;
        w_err_d = w_err_q | w_oor | (wlast != (w_left_q == 8'd0));
        w_idx_d = w_idx_q + ONE;
        w_left_d = w_left_q - 8'd1;
        w_state_d = (w_left_q == 8'd0) ? W_RESP : W_DATA;
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = w_state_d == W_IDLE;
    wready_d = w_state_d == W_DATA;
    bvalid_d = w_state_d == W_RESP;
    bresp_d = bvalid_d ? {w_err_d, 1'b0} : 2'b00;
  end
  always_ff @(posedge clk)
    if (w_en)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (wstrb[i]) mem[w_idx_q[MW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q <= '0;
      r_idx_q <= '0;
      r_left_q <= '0;
      arready_q <= 1'b1;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rresp_q <= 2'b00;
      rdata_q <= '0;
      w_state_q <= W_IDLE;
      w_idx_q <= '0;
      w_left_q <= '0;
      w_err_q <= 1'b0;
      awready_q <= 1'b1;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q <= r_cnt_d;
      r_idx_q <= r_idx_d;
      r_left_q <= r_left_d;
      arready_q <= arready_d;
      rvalid_q <= rvalid_d;
      rlast_q <= rlast_d;
      rresp_q <= rresp_d;
      rdata_q <= rdata_d;
      w_state_q <= w_state_d;
      w_idx_q <= w_idx_d;
      w_left_q <= w_left_d;
      w_err_q <= w_err_d;
      awready_q <= awready_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
    end
  end
  assign arready = arready_q;
  assign rvalid = rvalid_q;
  assign rlast = rlast_q;
  assign rresp = rresp_q;
  assign rdata = rdata_q;
  assign awready = awready_q;
  assign wready = wready_q;
  assign bvalid = bvalid_q;
  assign bresp = bresp_q;
endmodule
